// File: rtl/dbg_apb_arb.sv
// Round-robin arbiter that funnels several APB debug requesters onto one APB slave.
// Each requester gets a private pending register, a one-cycle pready pulse and a held read-data word.
module dbg_apb_arb #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_penable,
  input  logic [NUM_REQ-1:0]     i_req_pwrite,
  input  logic [NUM_REQ*32-1:0]  i_req_paddr,
  input  logic [NUM_REQ*32-1:0]  i_req_pwdata,
  output logic [NUM_REQ-1:0]     o_req_pready,
  output logic [NUM_REQ*32-1:0]  o_req_prdata,
  output logic                   o_penable,
  output logic                   o_pwrite,
  output logic [31:0]            o_paddr,
  output logic [31:0]            o_pwdata,
  input  logic                   i_pready,
  input  logic [31:0]            i_prdata,
  input  logic                   i_err_clr,
  output logic                   o_err_timeout,
  output logic [NUM_REQ-1:0]     o_err_drop,
  output logic                   o_dbg_state
);

  // Handshake: a requester raises penable and holds it (or pulses it once); the transfer is
  // captured when the port is not busy, and completes with exactly one o_req_pready pulse.
  // On the slave side o_penable stays high with stable controls until i_pready or timeout.

  localparam int          GW           = $clog2(NUM_REQ);
  localparam logic [15:0] WAIT_LAST    = 16'(TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t               state;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        last_grant;
  logic [15:0]          wait_cnt;

  logic [NUM_REQ-1:0]   busy;
  logic [NUM_REQ-1:0]   pen_q;
  logic [NUM_REQ-1:0]   pend_write;
  logic [31:0]          pend_addr  [NUM_REQ];
  logic [31:0]          pend_wdata [NUM_REQ];
  logic [31:0]          prdata_q   [NUM_REQ];

  logic                 wait_hit;
  logic                 slv_done;
  logic                 to_evt;
  logic [NUM_REQ-1:0]   done_vec;
  logic [NUM_REQ-1:0]   capture;
  logic [NUM_REQ-1:0]   drop_evt;
  logic                 pick_valid;
  logic [GW-1:0]        pick;

  assign wait_hit = (wait_cnt == WAIT_LAST);
  assign slv_done = (state == ACCESS) && (i_pready || wait_hit);
  assign to_evt   = (state == ACCESS) && !i_pready && wait_hit;

  always_comb begin
    done_vec = '0;
    if (slv_done) done_vec[grant] = 1'b1;
  end

  // The pready pulse cycle blocks capture so a held penable is not taken as a new transfer.
  assign capture  = i_req_penable & ~busy & ~o_req_pready;
  assign drop_evt = i_req_penable & ~pen_q & busy;

  // Round-robin search from last_grant+1; the lowest offset that is busy wins.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    idx        = 0;
    cand       = '0;
    pick_valid = 1'b0;
    pick       = last_grant;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = GW'(idx);
      if (busy[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Per-port capture, busy tracking and dropped-request flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy       <= '0;
      pen_q      <= '0;
      pend_write <= '0;
      o_err_drop <= '0;
      for (int p = 0; p < NUM_REQ; p++) begin
        pend_addr[p]  <= '0;
        pend_wdata[p] <= '0;
      end
    end else begin
      pen_q <= i_req_penable;
      for (int p = 0; p < NUM_REQ; p++) begin
        if (done_vec[p]) begin
          busy[p] <= 1'b0;
        end else if (capture[p]) begin
          busy[p]       <= 1'b1;
          pend_write[p] <= i_req_pwrite[p];
          pend_addr[p]  <= i_req_paddr[p*32 +: 32];
          pend_wdata[p] <= i_req_pwdata[p*32 +: 32];
        end
        if (drop_evt[p]) begin
          o_err_drop[p] <= 1'b1;
        end else if (i_err_clr) begin
          o_err_drop[p] <= 1'b0;
        end
      end
    end
  end

  // Arbitration FSM with registered slave-side and completion outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= GW'(NUM_REQ - 1);
      wait_cnt      <= '0;
      o_penable     <= 1'b0;
      o_pwrite      <= 1'b0;
      o_paddr       <= '0;
      o_pwdata      <= '0;
      o_req_pready  <= '0;
      o_err_timeout <= 1'b0;
      for (int p = 0; p < NUM_REQ; p++) prdata_q[p] <= '0;
    end else begin
      o_req_pready <= '0;
      if (to_evt) begin
        o_err_timeout <= 1'b1;
      end else if (i_err_clr) begin
        o_err_timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant     <= pick;
            o_pwrite  <= pend_write[pick];
            o_paddr   <= pend_addr[pick];
            o_pwdata  <= pend_wdata[pick];
            o_penable <= 1'b1;
            wait_cnt  <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (slv_done) begin
            o_penable           <= 1'b0;
            prdata_q[grant]     <= i_pready ? i_prdata : TIMEOUT_DATA;
            o_req_pready[grant] <= 1'b1;
            last_grant          <= grant;
            state               <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_REQ; p++) begin : g_rdata
    assign o_req_prdata[p*32 +: 32] = prdata_q[p];
  end

  assign o_dbg_state = state;

  a_pready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_req_pready));

  a_access_penable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state == ACCESS) |-> (o_penable && busy[grant]));

  a_access_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state == ACCESS && !slv_done) |=>
      ($stable(o_paddr) && $stable(o_pwdata) && $stable(o_pwrite) && o_penable));

endmodule

// File: tb/tb_dbg_apb_arb.sv
// Directed bench for dbg_apb_arb: two requesters, TIMEOUT=4, scripted slave with
// programmable wait states, access log compared against hand-computed expectations.
module tb_dbg_apb_arb;

  logic        i_clk;
  logic        i_rst_n;
  logic [1:0]  i_req_penable;
  logic [1:0]  i_req_pwrite;
  logic [63:0] i_req_paddr;
  logic [63:0] i_req_pwdata;
  logic [1:0]  o_req_pready;
  logic [63:0] o_req_prdata;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_paddr;
  logic [31:0] o_pwdata;
  logic        i_pready;
  logic [31:0] i_prdata;
  logic        i_err_clr;
  logic        o_err_timeout;
  logic [1:0]  o_err_drop;
  logic        o_dbg_state;

  logic        req_pen   [2];
  logic        req_w     [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];

  assign i_req_penable = {req_pen[1], req_pen[0]};
  assign i_req_pwrite  = {req_w[1], req_w[0]};
  assign i_req_paddr   = {req_addr[1], req_addr[0]};
  assign i_req_pwdata  = {req_wdata[1], req_wdata[0]};

  logic [31:0] prd0;
  logic [31:0] prd1;
  assign prd0 = o_req_prdata[31:0];
  assign prd1 = o_req_prdata[63:32];

  dbg_apb_arb #(.NUM_REQ(2), .TIMEOUT(4)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_penable (i_req_penable),
    .i_req_pwrite  (i_req_pwrite),
    .i_req_paddr   (i_req_paddr),
    .i_req_pwdata  (i_req_pwdata),
    .o_req_pready  (o_req_pready),
    .o_req_prdata  (o_req_prdata),
    .o_penable     (o_penable),
    .o_pwrite      (o_pwrite),
    .o_paddr       (o_paddr),
    .o_pwdata      (o_pwdata),
    .i_pready      (i_pready),
    .i_prdata      (i_prdata),
    .i_err_clr     (i_err_clr),
    .o_err_timeout (o_err_timeout),
    .o_err_drop    (o_err_drop),
    .o_dbg_state   (o_dbg_state)
  );

  // Clock and watchdog
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Slave model: answers after slv_wait low cycles, or never when slv_hang is set.
  int          slv_cnt;
  int          slv_wait;
  logic        slv_hang;
  logic [31:0] slv_rdata;
  assign i_prdata = slv_rdata;

  always @(negedge i_clk) begin
    if (o_penable) begin
      if (!slv_hang && slv_cnt == slv_wait) begin
        i_pready = 1'b1;
      end else begin
        i_pready = 1'b0;
        slv_cnt  = slv_cnt + 1;
      end
    end else begin
      i_pready = 1'b0;
      slv_cnt  = 0;
    end
  end

  // Monitor: logs slave access starts and requester completion pulses.
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  int          acc_cyc_q[$];
  int          pulses    [2];
  int          pulse_cyc [2];
  int          cyc;
  logic        pen_prev;

  always @(posedge i_clk) begin
    #1;
    cyc = cyc + 1;
    if (o_penable && !pen_prev) begin
      acc_q.push_back(o_paddr);
      acc_cyc_q.push_back(cyc);
    end
    pen_prev = o_penable;
    for (int p = 0; p < 2; p++) begin
      if (o_req_pready[p]) begin
        pulses[p]    = pulses[p] + 1;
        pulse_cyc[p] = cyc;
      end
    end
    if (o_req_pready != 2'b00) check("pready_onehot", 32'($countones(o_req_pready)), 32'd1);
  end

  // Driver tasks
  task automatic wait_pready(input int p, input int budget);
    int n;
    n = 0;
    while (!o_req_pready[p] && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check($sformatf("pready%0d_seen", p), 32'(o_req_pready[p]), 32'd1);
  endtask

  task automatic wait_pen(input int budget);
    int n;
    n = 0;
    while (!o_penable && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check("penable_seen", 32'(o_penable), 32'd1);
  endtask

  task automatic hold_xfer(input int p, input logic w, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_pen[p]   = 1'b1;
    req_w[p]     = w;
    req_addr[p]  = addr;
    req_wdata[p] = wdata;
    @(negedge i_clk);
    wait_pready(p, 40);
    @(negedge i_clk);
    req_pen[p] = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic clear_log();
    acc_q.delete();
    acc_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic score(input string tag);
    logic [31:0] e;
    logic [31:0] o;
    check({tag, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hxxxx_xxxx;
      check(tag, o, e);
    end
  endtask

  int base0;
  int base1;

  initial begin
    i_rst_n   = 1'b0;
    i_err_clr = 1'b0;
    i_pready  = 1'b0;
    slv_cnt   = 0;
    slv_wait  = 0;
    slv_hang  = 1'b0;
    slv_rdata = '0;
    cyc       = 0;
    pen_prev  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_pen[p]   = 1'b0;
      req_w[p]     = 1'b0;
      req_addr[p]  = '0;
      req_wdata[p] = '0;
      pulses[p]    = 0;
      pulse_cyc[p] = 0;
    end
    repeat (2) @(negedge i_clk);

    // Reset values
    check("rst_penable", 32'(o_penable), 32'd0);
    check("rst_pwrite", 32'(o_pwrite), 32'd0);
    check("rst_paddr", o_paddr, 32'd0);
    check("rst_pwdata", o_pwdata, 32'd0);
    check("rst_pready", 32'(o_req_pready), 32'd0);
    check("rst_prdata0", prd0, 32'd0);
    check("rst_prdata1", prd1, 32'd0);
    check("rst_err_to", 32'(o_err_timeout), 32'd0);
    check("rst_err_drop", 32'(o_err_drop), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Latency N / N+2 / N+3 with a zero-wait slave, held penable not recaptured
    clear_log();
    slv_wait  = 0;
    slv_rdata = 32'hA5A5_0001;
    req_pen[0] = 1'b1; req_w[0] = 1'b0; req_addr[0] = 32'h0000_0100;
    @(negedge i_clk);
    check("lat_n1_idle", 32'(o_penable), 32'd0);
    @(negedge i_clk);
    check("lat_n2_pen", 32'(o_penable), 32'd1);
    check("lat_n2_addr", o_paddr, 32'h0000_0100);
    check("lat_n2_nordy", 32'(o_req_pready), 32'd0);
    @(negedge i_clk);
    check("lat_n3_rdy", 32'(o_req_pready), 32'd1);
    check("lat_n3_data", prd0, 32'hA5A5_0001);
    check("lat_n3_pen", 32'(o_penable), 32'd0);
    @(negedge i_clk);
    req_pen[0] = 1'b0;
    check("lat_rdy_single", 32'(o_req_pready), 32'd0);
    @(negedge i_clk);
    check("lat_no_recap", 32'(o_penable), 32'd0);
    exp_q.push_back(32'h0000_0100);
    score("lat_acc");

    // Read with three wait cycles (stays just below the timeout)
    clear_log();
    slv_wait  = 3;
    slv_rdata = 32'h1234_5678;
    base0 = pulses[0];
    hold_xfer(0, 1'b0, 32'h0000_1000, 32'd0);
    repeat (3) @(negedge i_clk);
    check("rd3_pulses", 32'(pulses[0] - base0), 32'd1);
    check("rd3_data", prd0, 32'h1234_5678);
    check("rd3_other_hold", prd1, 32'd0);
    check("rd3_no_timeout", 32'(o_err_timeout), 32'd0);
    check("rd3_duration", 32'(pulse_cyc[0] - acc_cyc_q[0]), 32'd4);
    exp_q.push_back(32'h0000_1000);
    score("rd3_acc");

    // Simultaneous requests after reset: port0 then port1, one idle cycle between
    do_reset();
    clear_log();
    slv_wait = 1;
    fork
      hold_xfer(0, 1'b0, 32'h0000_1000, 32'd0);
      hold_xfer(1, 1'b1, 32'h0000_2000, 32'h0000_0055);
    join
    repeat (2) @(negedge i_clk);
    check("rr_gap", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd3);
    exp_q.push_back(32'h0000_1000);
    exp_q.push_back(32'h0000_2000);
    score("rr_order");

    // Port0 write pulses against a continuously reading port1
    do_reset();
    clear_log();
    slv_wait = 1;
    req_pen[1] = 1'b1; req_w[1] = 1'b0; req_addr[1] = 32'h0000_2000;
    for (int i = 0; i < 3; i++) begin
      req_pen[0]   = 1'b1;
      req_w[0]     = 1'b1;
      req_addr[0]  = 32'h0000_1000 + 32'(4 * i);
      req_wdata[0] = 32'(i);
      @(negedge i_clk);
      req_pen[0] = 1'b0;
      wait_pready(0, 40);
      @(negedge i_clk);
    end
    wait_pready(1, 40);
    @(negedge i_clk);
    req_pen[1] = 1'b0;
    repeat (4) @(negedge i_clk);
    exp_q.push_back(32'h0000_1000);
    exp_q.push_back(32'h0000_2000);
    exp_q.push_back(32'h0000_1004);
    exp_q.push_back(32'h0000_2000);
    exp_q.push_back(32'h0000_1008);
    exp_q.push_back(32'h0000_2000);
    score("alt_order");
    check("alt_no_drop", 32'(o_err_drop), 32'd0);

    // Slave never answers: forced completion after 4 wait cycles
    clear_log();
    slv_hang = 1'b1;
    hold_xfer(0, 1'b0, 32'h0000_3000, 32'd0);
    check("to_data", prd0, 32'hDEAD_BEEF);
    check("to_flag", 32'(o_err_timeout), 32'd1);
    check("to_duration", 32'(pulse_cyc[0] - acc_cyc_q[0]), 32'd4);
    repeat (3) @(negedge i_clk);
    check("to_sticky", 32'(o_err_timeout), 32'd1);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    check("to_clr", 32'(o_err_timeout), 32'd0);

    // Timeout while clear is held: set wins, clear applies on the following edge
    i_err_clr  = 1'b1;
    req_pen[0] = 1'b1; req_w[0] = 1'b0; req_addr[0] = 32'h0000_3004;
    @(negedge i_clk);
    wait_pready(0, 40);
    check("to_set_over_clr", 32'(o_err_timeout), 32'd1);
    @(negedge i_clk);
    req_pen[0] = 1'b0;
    check("to_clr_after", 32'(o_err_timeout), 32'd0);
    i_err_clr = 1'b0;
    slv_hang  = 1'b0;
    repeat (2) @(negedge i_clk);

    // Second pulse from a busy port1 is dropped; write loads prdata too
    clear_log();
    slv_wait  = 3;
    slv_rdata = 32'h0BAD_F00D;
    base1 = pulses[1];
    req_w[1] = 1'b1; req_addr[1] = 32'h0000_2100; req_wdata[1] = 32'hCAFE_0001;
    req_pen[1] = 1'b1;
    @(negedge i_clk);
    req_pen[1] = 1'b0;
    @(negedge i_clk);
    check("drop_pwrite", 32'(o_pwrite), 32'd1);
    check("drop_paddr", o_paddr, 32'h0000_2100);
    check("drop_pwdata", o_pwdata, 32'hCAFE_0001);
    req_pen[1] = 1'b1;
    @(negedge i_clk);
    req_pen[1] = 1'b0;
    check("drop_flag", 32'(o_err_drop), 32'b10);
    check("drop_stable", o_pwdata, 32'hCAFE_0001);
    wait_pready(1, 40);
    repeat (4) @(negedge i_clk);
    check("drop_pulses", 32'(pulses[1] - base1), 32'd1);
    check("drop_wr_rdata", prd1, 32'h0BAD_F00D);
    check("drop_sticky", 32'(o_err_drop), 32'b10);
    exp_q.push_back(32'h0000_2100);
    score("drop_acc");
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    check("drop_clr", 32'(o_err_drop), 32'd0);

    // Reset in the middle of an access
    slv_hang = 1'b1;
    base0 = pulses[0];
    req_pen[0] = 1'b1; req_w[0] = 1'b0; req_addr[0] = 32'h0000_4000;
    @(negedge i_clk);
    wait_pen(40);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("rstmid_pen", 32'(o_penable), 32'd0);
    check("rstmid_rdy", 32'(o_req_pready), 32'd0);
    req_pen[0] = 1'b0;
    slv_hang   = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);
    check("rstmid_no_pulse", 32'(pulses[0] - base0), 32'd0);
    check("rstmid_prdata", prd0, 32'd0);
    clear_log();
    slv_wait  = 0;
    slv_rdata = 32'h7777_0000;
    hold_xfer(1, 1'b0, 32'h0000_2200, 32'd0);
    repeat (2) @(negedge i_clk);
    check("rstmid_after_data", prd1, 32'h7777_0000);
    exp_q.push_back(32'h0000_2200);
    score("rstmid_after_acc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
